gpio_write_regfile: RTL and testbench
=====================================

GPIO_WRITE_REGFILE -- requirements
Module: gpio_write_regfile

Interface
REQ-001 Parameter NUM_REGS, default 8, number of committed output registers (1..255).
REQ-002 Parameter REG_BYTES, default 4, bytes per register (1..8).
REQ-003 Parameter BASE_ADDR, default 16'h0100, GPIO address of register 0 byte 0.
REQ-004 Parameter SYNC_STAGES, default 2, synchronizer depth for the GPIO write strobe (2..4).
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 gpio_in  input  32  [15:0] addr, [23:16] data, [24] w_clk write strobe, [31:25] ignored; asynchronous to clk.
REQ-008 gpio_out_bus  output  32  readback/status word.
REQ-009 reg_out  output  NUM_REGS*REG_BYTES*8  committed registers, register i at bits [i*REG_BYTES*8 +: REG_BYTES*8].
REQ-010 reg_update  output  NUM_REGS  one-cycle pulse per register on commit.

Function
REQ-011 Address map: SHADOW region BASE_ADDR .. BASE_ADDR+NUM_REGS*REG_BYTES-1; COMMIT_ADDR = region end; CLEAR_ADDR = COMMIT_ADDR+1.
REQ-012 w_clk passes through SYNC_STAGES flops; a write event is a 0->1 transition at the synchronizer output.
REQ-013 addr/data are registered every cycle; a write event uses the registered values (CPU holds addr/data stable while toggling w_clk).
REQ-014 Write latency: state change visible exactly SYNC_STAGES+1 clk edges after the first edge sampling w_clk=1.
REQ-015 w_clk held high produces exactly one write event; a new event requires w_clk to return to 0.
REQ-016 SHADOW write: offset = addr-BASE_ADDR; shadow byte (offset mod REG_BYTES) of register (offset / REG_BYTES) takes data; reg_out unchanged.
REQ-017 COMMIT write, data < NUM_REGS: reg_out[data] <= shadow[data]; reg_update[data] pulses high for one cycle, same cycle reg_out changes.
REQ-018 COMMIT write, data = 8'hFF: all registers commit simultaneously; all reg_update bits pulse together.
REQ-019 COMMIT write, other data: no register change, no pulse, sticky error flag set.
REQ-020 CLEAR write (any data): error flag cleared; a shadow or commit write never clears it.
REQ-021 Writes outside SHADOW/COMMIT/CLEAR are ignored and not counted.
REQ-022 Write counter: 8-bit, increments on every accepted SHADOW/COMMIT/CLEAR event (including erroneous commits), wraps 255->0.
REQ-023 gpio_out_bus[7:0] = shadow byte at registered addr if in SHADOW region else 8'h00, registered (one cycle after addr register).
REQ-024 gpio_out_bus[15:8] = write counter; [16] = error flag; [31:17] = 0.
REQ-025 Commit in the same cycle as a shadow write is impossible (one event per cycle); a commit always uses shadow contents including the immediately preceding write.

Reset
REQ-026 On rst low: shadow, reg_out, reg_update, counter, error flag, gpio_out_bus all 0; synchronizer and edge-history flops set to 1.
REQ-027 w_clk high at reset release produces no write event; w_clk low at release arms normally.
REQ-028 Reset asserted mid-write discards the in-flight event; no partial update survives.

Structure
REQ-029 Package gpio_regfile_pkg holds GPIO field offsets (ADDR_LSB=0, DATA_LSB=16, WCLK_BIT=24), COMMIT_ALL=8'hFF, status bit positions.
REQ-030 One sub-module gpio_edge_sync (parametrised depth synchronizer + rising-edge detect, reset-to-1); everything else in gpio_write_regfile.
REQ-031 Elaboration check: COMMIT_ADDR+1 fits in 16 bits, NUM_REGS <= 255.

Verification (defaults: COMMIT_ADDR=16'h0120, CLEAR_ADDR=16'h0121)
REQ-032 Write 0x0104<=0xAB, 0x0105<=0xCD, commit data 0x01 -> reg_out reg1 = 0x0000CDAB, reg_update = 8'b0000_0010 for one cycle, counter = 3, other registers 0.
REQ-033 Shadow-fill regs 0..7 with i*0x11111111, commit 0xFF -> all reg_out updated same cycle, reg_update = 8'hFF one cycle.
REQ-034 Commit data 0x09 -> reg_out unchanged, gpio_out_bus[16]=1; write 0x0121 -> [16]=0.
REQ-035 w_clk pulse, measure edges -> shadow change at edge SYNC_STAGES+1 (3); w_clk held high 20 cycles -> counter +1 only.
REQ-036 Write to 0x0050 and 0x0200 -> no state or counter change; 256 valid writes -> counter wraps to 0.
REQ-037 Hold w_clk=1 through reset release -> no write; assert rst during write -> all outputs 0, later writes work normally.

Source files
------------

// File: rtl/gpio_regfile_pkg.sv
// Shared constants for the GPIO-driven register file: GPIO field layout,
// status word layout and the decoded write-event kinds.
package gpio_regfile_pkg;

    // Fields of the 32-bit GPIO input word
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_LSB = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned WCLK_BIT = 24;

    // Commit data value that commits every register at once
    localparam logic [7:0] COMMIT_ALL = 8'hFF;

    // Fields of the 32-bit status/readback word
    localparam int unsigned STAT_RD_LSB  = 0;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_ERR_BIT = 16;

    // Target of a write event after address decode
    typedef enum logic [1:0] {
        WrNone,
        WrShadow,
        WrCommit,
        WrClear
    } wr_kind_e;

endpackage

// File: rtl/gpio_edge_sync.sv
// Multi-flop synchronizer with rising-edge detect. All flops reset to 1 so a
// line that is already high when reset releases never looks like a new edge.
module gpio_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the asynchronous input through the chain and keep one cycle of history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // One-cycle pulse on a 0->1 transition at the synchronizer output
    always_comb begin
        rise_o = sync_q[STAGES-1] & ~prev_q;
    end

endmodule

// File: rtl/gpio_write_regfile.sv
// Register file written byte-by-byte over a bit-banged GPIO port. Bytes land in
// a shadow copy; a commit write copies one (or all) shadow registers to the
// outputs with a one-cycle update pulse. A status word reports the shadow byte
// at the current address, a write counter and a sticky commit-error flag.
module gpio_write_regfile
    import gpio_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned REG_BYTES   = 4,
    parameter logic [15:0] BASE_ADDR   = 16'h0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       gpio_in,
    output logic [31:0]                       gpio_out_bus,
    output logic [NUM_REGS*REG_BYTES*8-1:0]   reg_out,
    output logic [NUM_REGS-1:0]               reg_update
);

    localparam int unsigned REG_W       = REG_BYTES * 8;
    localparam int unsigned TOTAL_BYTES = NUM_REGS * REG_BYTES;
    localparam int unsigned TOTAL_W     = TOTAL_BYTES * 8;
    localparam int unsigned BASE_U      = {16'd0, BASE_ADDR};
    localparam int unsigned COMMIT_U    = BASE_U + TOTAL_BYTES;
    localparam int unsigned CLEAR_U     = COMMIT_U + 1;

    // Parameter sanity: the clear address must still be a 16-bit address
    if (CLEAR_U > 32'h0000_FFFF) begin : g_addr_range_err
        $error("CLEAR address does not fit in 16 bits");
    end
    if (NUM_REGS < 1 || NUM_REGS > 255) begin : g_num_regs_err
        $error("NUM_REGS must be 1..255");
    end
    if (REG_BYTES < 1 || REG_BYTES > 8) begin : g_reg_bytes_err
        $error("REG_BYTES must be 1..8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_err
        $error("SYNC_STAGES must be 2..4");
    end

    // Registered GPIO fields (CPU holds them stable around the strobe)
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Architectural state
    logic [TOTAL_W-1:0]  shadow_q, shadow_d;
    logic [TOTAL_W-1:0]  reg_q, reg_d;
    logic [NUM_REGS-1:0] upd_q, upd_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [7:0]          rd_q, rd_d;

    // Decode results
    logic        wr_ev;
    wr_kind_e    wr_kind;
    logic [31:0] addr_u;
    logic [31:0] offset;
    logic        commit_one;

    // Bits [31:25] of the GPIO word carry nothing for this block
    logic unused_gpio_hi;
    assign unused_gpio_hi = ^gpio_in[31:25];

    gpio_edge_sync #(
        .STAGES(SYNC_STAGES)
    ) u_wclk_sync (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   (gpio_in[WCLK_BIT]),
        .rise_o(wr_ev)
    );

    // Sample address and data every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= gpio_in[ADDR_LSB +: ADDR_W];
            data_q <= gpio_in[DATA_LSB +: DATA_W];
        end
    end

    // Classify the registered address into shadow / commit / clear / ignored
    always_comb begin
        addr_u  = {16'd0, addr_q};
        offset  = addr_u - BASE_U;
        wr_kind = WrNone;
        if (addr_u >= BASE_U && addr_u < COMMIT_U) begin
            wr_kind = WrShadow;
        end else if (addr_u == COMMIT_U) begin
            wr_kind = WrCommit;
        end else if (addr_u == CLEAR_U) begin
            wr_kind = WrClear;
        end
        commit_one = ({24'd0, data_q} < NUM_REGS);
    end

    // Next-state for shadow, committed registers, update pulses, counter, error flag
    always_comb begin
        shadow_d = shadow_q;
        reg_d    = reg_q;
        upd_d    = '0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (wr_ev && wr_kind != WrNone) begin
            // Every accepted event counts, including a rejected commit
            cnt_d = cnt_q + 8'd1;
            case (wr_kind)
                WrShadow: begin
                    for (int unsigned b = 0; b < TOTAL_BYTES; b++) begin
                        if (offset == b) begin
                            shadow_d[b*8 +: 8] = data_q;
                        end
                    end
                end
                WrCommit: begin
                    if (data_q == COMMIT_ALL) begin
                        reg_d = shadow_q;
                        upd_d = '1;
                    end else if (commit_one) begin
                        for (int unsigned r = 0; r < NUM_REGS; r++) begin
                            if (data_q == 8'(r)) begin
                                reg_d[r*REG_W +: REG_W] = shadow_q[r*REG_W +: REG_W];
                                upd_d[r]                = 1'b1;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                WrClear: begin
                    err_d = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Shadow byte addressed by the registered address, zero outside the region
    always_comb begin
        rd_d = '0;
        if (wr_kind == WrShadow) begin
            for (int unsigned b = 0; b < TOTAL_BYTES; b++) begin
                if (offset == b) begin
                    rd_d = shadow_q[b*8 +: 8];
                end
            end
        end
    end

    // State update; reset discards any in-flight event along with all contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            reg_q    <= '0;
            upd_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            reg_q    <= reg_d;
            upd_q    <= upd_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        reg_out                              = reg_q;
        reg_update                           = upd_q;
        gpio_out_bus                         = '0;
        gpio_out_bus[STAT_RD_LSB +: 8]       = rd_q;
        gpio_out_bus[STAT_CNT_LSB +: 8]      = cnt_q;
        gpio_out_bus[STAT_ERR_BIT]           = err_q;
    end

endmodule

// File: tb/tb_gpio_write_regfile.sv
// Randomized self-checking bench for gpio_write_regfile with default parameters.
// A byte-array model applies each GPIO write by the address-map rules and the
// bench compares outputs, write latency and update pulses against it.
module tb_gpio_write_regfile;

    localparam int S      = 2;
    localparam int NR     = 8;
    localparam int RB     = 4;
    localparam int BASE   = 16'h0100;
    localparam int COMMIT = 16'h0120;
    localparam int CLEAR  = 16'h0121;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  gpio_in = '0;
    logic [31:0]  gpio_out_bus;
    logic [255:0] reg_out;
    logic [7:0]   reg_update;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [7:0]   shadow_m [NR*RB];
    logic [255:0] reg_m;
    logic [7:0]   cnt_m;
    logic         err_m;

    gpio_write_regfile #(
        .NUM_REGS   (NR),
        .REG_BYTES  (RB),
        .BASE_ADDR  (16'h0100),
        .SYNC_STAGES(S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_in     (gpio_in),
        .gpio_out_bus(gpio_out_bus),
        .reg_out     (reg_out),
        .reg_update  (reg_update)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR*RB; i++) shadow_m[i] = 8'h00;
        reg_m = '0;
        cnt_m = 8'h00;
        err_m = 1'b0;
    endtask

    function automatic logic [7:0] rd_model(input logic [15:0] a);
        int ai = int'(a);
        if (ai >= BASE && ai < COMMIT) return shadow_m[ai-BASE];
        return 8'h00;
    endfunction

    task automatic model_apply(input logic [15:0] a, input logic [7:0] d,
                               output bit acc, output logic [7:0] upd);
        int ai = int'(a);
        int di = int'(d);
        acc = 1'b0;
        upd = 8'h00;
        if (ai >= BASE && ai < COMMIT) begin
            shadow_m[ai-BASE] = d;
            acc = 1'b1;
        end else if (ai == COMMIT) begin
            acc = 1'b1;
            if (di < NR) begin
                for (int b = 0; b < RB; b++) reg_m[(di*RB+b)*8 +: 8] = shadow_m[di*RB+b];
                upd[di] = 1'b1;
            end else if (di == 255) begin
                for (int i = 0; i < NR*RB; i++) reg_m[i*8 +: 8] = shadow_m[i];
                upd = 8'hFF;
            end else begin
                err_m = 1'b1;
            end
        end else if (ai == CLEAR) begin
            acc   = 1'b1;
            err_m = 1'b0;
        end
        if (acc) cnt_m = cnt_m + 8'd1;
    endtask

    // One complete GPIO write: strobe high for 'hold' cycles, then watch it settle
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        bit           acc;
        logic [7:0]   exp_upd;
        logic [7:0]   cnt0;
        logic [255:0] reg0;
        logic [7:0]   upd_seen = 8'h00;
        int           cnt_k = 0;
        int           pulse_k = 0;
        int           reg_k = 0;
        int           pulses = 0;
        model_apply(a, d, acc, exp_upd);
        gpio_in = {7'd0, 1'b0, d, a};
        @(negedge clk);
        cnt0 = gpio_out_bus[15:8];
        reg0 = reg_out;
        gpio_in[24] = 1'b1;
        for (int k = 1; k <= hold + S + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (reg_update != 8'h00) begin
                pulses++;
                upd_seen = upd_seen | reg_update;
                if (pulse_k == 0) pulse_k = k;
            end
            if (cnt_k == 0 && gpio_out_bus[15:8] != cnt0) cnt_k = k;
            if (reg_k == 0 && reg_out != reg0) reg_k = k;
            if (k == hold) gpio_in[24] = 1'b0;
        end
        check_eq("wr_latency", 256'(cnt_k), 256'(acc ? S + 1 : 0));
        check_eq("upd_pulses", 256'(pulses), 256'((exp_upd != 8'h00) ? 1 : 0));
        check_eq("upd_mask", 256'(upd_seen), 256'(exp_upd));
        if (reg_k != 0) check_eq("reg_vs_pulse", 256'(reg_k), 256'(pulse_k));
        check_eq("reg_out", reg_out, reg_m);
        check_eq("counter", 256'(gpio_out_bus[15:8]), 256'(cnt_m));
        check_eq("err_flag", 256'(gpio_out_bus[16]), 256'(err_m));
        check_eq("rsvd_bits", 256'(gpio_out_bus[31:17]), 256'(0));
        check_eq("readback", 256'(gpio_out_bus[7:0]), 256'(rd_model(a)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_bus", 256'(gpio_out_bus), 256'(0));
        check_eq("rst_reg", reg_out, 256'(0));
        check_eq("rst_upd", 256'(reg_update), 256'(0));
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    logic [255:0] exp_all;
    logic [15:0]  ra;
    logic [7:0]   rd;
    int           kind;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("init_bus", 256'(gpio_out_bus), 256'(0));
        check_eq("init_reg", reg_out, 256'(0));
        check_eq("init_upd", 256'(reg_update), 256'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Two shadow bytes then commit register 1
        do_write(16'h0104, 8'hAB, 1);
        do_write(16'h0105, 8'hCD, 2);
        do_write(16'h0120, 8'h01, 3);
        check_eq("req032_reg", reg_out, 256'h0000CDAB << 32);
        check_eq("req032_cnt", 256'(gpio_out_bus[15:8]), 256'(3));

        // Fill all shadows with i*0x11111111 and commit all
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < RB; b++)
                do_write(16'(BASE + i*RB + b), 8'(i * 17), 1);
        do_write(16'h0120, 8'hFF, 2);
        exp_all = '0;
        for (int i = 0; i < NR; i++) exp_all[i*32 +: 32] = 32'(i) * 32'h11111111;
        check_eq("req033_reg", reg_out, exp_all);

        // Bad commit sets the sticky flag; clear drops it
        do_write(16'h0120, 8'h09, 1);
        check_eq("req034_reg", reg_out, exp_all);
        check_eq("req034_err_set", 256'(gpio_out_bus[16]), 256'(1));
        do_write(16'h0104, 8'h12, 1);
        check_eq("req034_err_sticky", 256'(gpio_out_bus[16]), 256'(1));
        do_write(16'h0121, 8'h00, 1);
        check_eq("req034_err_clr", 256'(gpio_out_bus[16]), 256'(0));

        // Strobe held high for 20 cycles: one event only
        do_write(16'h0100, 8'h3C, 20);

        // Out-of-map addresses are ignored
        do_write(16'h0050, 8'h77, 2);
        do_write(16'h0200, 8'h88, 2);

        // Random mix of all write kinds
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 9));
            rd   = 8'($urandom);
            if (kind <= 5) begin
                ra = 16'(BASE + int'($urandom_range(0, NR*RB-1)));
            end else if (kind <= 7) begin
                ra = 16'(COMMIT);
                case ($urandom_range(0, 2))
                    0: rd = 8'($urandom_range(0, NR-1));
                    1: rd = 8'hFF;
                    default: rd = 8'($urandom_range(NR, 254));
                endcase
            end else if (kind == 8) begin
                ra = 16'(CLEAR);
            end else if ($urandom_range(0, 1) == 0) begin
                ra = 16'($urandom_range(0, BASE-1));
            end else begin
                ra = 16'($urandom_range(CLEAR+1, 16'hFFFF));
            end
            do_write(ra, rd, int'($urandom_range(1, 6)));
        end

        // Reset in the middle of a write discards it
        gpio_in = {8'd0, 8'h77, 16'h0100};
        @(negedge clk);
        gpio_in[24] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_bus", 256'(gpio_out_bus), 256'(0));
        check_eq("midrst_reg", reg_out, 256'(0));
        check_eq("midrst_upd", 256'(reg_update), 256'(0));
        model_reset();
        gpio_in[24] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("midrst_cnt", 256'(gpio_out_bus[15:8]), 256'(0));
        check_eq("midrst_rd", 256'(gpio_out_bus[7:0]), 256'(0));
        do_write(16'h0100, 8'h42, 2);

        // Strobe high through reset release: no event, not even when it drops
        @(negedge clk);
        rst = 1'b0;
        gpio_in = {7'd0, 1'b1, 8'h5A, 16'h0100};
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("hold_rel_cnt", 256'(gpio_out_bus[15:8]), 256'(0));
        check_eq("hold_rel_rd", 256'(gpio_out_bus[7:0]), 256'(0));
        gpio_in[24] = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("hold_rel_cnt2", 256'(gpio_out_bus[15:8]), 256'(0));
        do_write(16'h0101, 8'h99, 1);

        // 256 accepted writes wrap the counter back to zero
        do_reset();
        for (int n = 0; n < 256; n++) do_write(16'h0121, 8'($urandom), 1);
        check_eq("cnt_wrap", 256'(gpio_out_bus[15:8]), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
